// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: miss/prefetch controller for a 2-way, 16-set, 64-bit-line instruction cache.
// Ports:
//   clock, reset                        clock and synchronous active-high reset
//   proc2Icache_addr                    fetch address (offset [2:0], index [6:3], tag [15:7])
//   Imem2proc_response/_data/_tag       bus accept tag, returning line data, and its transaction tag
//   cachemem_data/_valid                demand lookup result from cache memory
//   cachemem_prefetch_valid             prefetch lookup hit from cache memory
//   proc2Imem_command/_addr             BUS_LOAD request and line-aligned address
//   Icache_data_out/_valid_out          line returned to fetch
//   rd1_idx/rd1_tag                     demand lookup index/tag
//   prefetch_rd_idx/prefetch_rd_tag     prefetch lookup index/tag
//   wr1_en/_idx/_tag/_data              fill write into cache memory
module icache_fill_ctrl #(
    parameter int NUM_MSHR = 4,
    parameter int PF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] proc2Icache_addr,
    input  logic [3:0]  Imem2proc_response,
    input  logic [63:0] Imem2proc_data,
    input  logic [3:0]  Imem2proc_tag,
    input  logic [63:0] cachemem_data,
    input  logic        cachemem_valid,
    input  logic        cachemem_prefetch_valid,
    output logic [1:0]  proc2Imem_command,
    output logic [63:0] proc2Imem_addr,
    output logic [63:0] Icache_data_out,
    output logic        Icache_valid_out,
    output logic [3:0]  rd1_idx,
    output logic [8:0]  rd1_tag,
    output logic [3:0]  prefetch_rd_idx,
    output logic [8:0]  prefetch_rd_tag,
    output logic        wr1_en,
    output logic [3:0]  wr1_idx,
    output logic [8:0]  wr1_tag,
    output logic [63:0] wr1_data
);
    localparam int IW = NUM_MSHR > 1 ? $clog2(NUM_MSHR) : 1;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic [NUM_MSHR-1:0] mshr_valid;
    logic [3:0]          mshr_tag  [NUM_MSHR];
    logic [12:0]         mshr_line [NUM_MSHR];
    logic [12:0]         pf_line;
    logic [12:0]         last_miss_line;
    logic [2:0]          pf_count;

    logic [12:0]   line;
    logic [12:0]   fill_line;
    logic [12:0]   req_line;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] free_idx;
    logic          fill_hit;
    logic          free_avail;
    logic          demand_in_flight;
    logic          pf_in_flight;
    logic          fill_cur;
    logic          demand_miss;
    logic          demand_req;
    logic          pf_active;
    logic          pf_skip;
    logic          pf_req;
    logic          accepted;
    logic          unused_addr_bits;

    assign line = proc2Icache_addr[15:3];
    assign unused_addr_bits = ^{proc2Icache_addr[63:16], proc2Icache_addr[2:0]};

    // Descending scan so the lowest matching/free entry wins.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        fill_line = '0;
        free_avail = 1'b0;
        free_idx = '0;
        demand_in_flight = 1'b0;
        pf_in_flight = 1'b0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (mshr_valid[i] && Imem2proc_tag != 4'd0 && mshr_tag[i] == Imem2proc_tag) begin
                fill_hit = 1'b1;
                fill_idx = IW'(i);
                fill_line = mshr_line[i];
            end
            if (!mshr_valid[i]) begin
                free_avail = 1'b1;
                free_idx = IW'(i);
            end
            demand_in_flight = demand_in_flight | (mshr_valid[i] && mshr_line[i] == line);
            pf_in_flight = pf_in_flight | (mshr_valid[i] && mshr_line[i] == pf_line);
        end
    end

    // A fill for the current line counts as a hit, so it neither requests nor redirects prefetch.
    assign fill_cur    = fill_hit && fill_line == line;
    assign demand_miss = !reset && !cachemem_valid && !fill_cur;
    assign demand_req  = demand_miss && !demand_in_flight && free_avail;
    assign pf_active   = !reset && !demand_req && pf_count != 3'd0;
    assign pf_skip     = pf_active && (cachemem_prefetch_valid || pf_in_flight);
    assign pf_req      = pf_active && !pf_skip && free_avail;
    assign req_line    = demand_req ? line : pf_line;
    assign accepted    = (demand_req || pf_req) && Imem2proc_response != 4'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            mshr_valid <= '0;
            pf_line <= '0;
            pf_count <= '0;
            last_miss_line <= '1;
        end else begin
            if (fill_hit) mshr_valid[fill_idx] <= 1'b0;
            if (accepted) begin
                mshr_valid[free_idx] <= 1'b1;
                mshr_tag[free_idx] <= Imem2proc_response;
                mshr_line[free_idx] <= req_line;
            end
            if (demand_miss && line != last_miss_line) begin
                pf_line <= line + 13'd1;
                pf_count <= 3'(PF_DEPTH);
                last_miss_line <= line;
            end else if ((pf_req && accepted) || pf_skip) begin
                pf_line <= pf_line + 13'd1;
                pf_count <= pf_count - 3'd1;
            end
        end
    end

    assign proc2Imem_command = (demand_req || pf_req) ? BUS_LOAD : BUS_NONE;
    assign proc2Imem_addr    = {48'b0, req_line, 3'b0};
    assign Icache_valid_out  = !reset && (cachemem_valid || fill_cur);
    assign Icache_data_out   = cachemem_valid ? cachemem_data : Imem2proc_data;
    assign rd1_idx           = proc2Icache_addr[6:3];
    assign rd1_tag           = proc2Icache_addr[15:7];
    assign prefetch_rd_idx   = pf_line[3:0];
    assign prefetch_rd_tag   = pf_line[12:4];
    assign wr1_en            = !reset && fill_hit;
    assign wr1_idx           = fill_line[3:0];
    assign wr1_tag           = fill_line[12:4];
    assign wr1_data          = Imem2proc_data;
endmodule
